// File: rtl/adc_wave_meter_pkg.sv
// Constants and state encoding shared by the ADC capture meter and the DDS generator.
package wave_pkg;
  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned SMP_W = 8;
  localparam logic [SMP_W-1:0] MIDSCALE = 8'h80;

  typedef enum logic {WARMUP, RUN} meter_state_t;

  function automatic logic signed [SMP_W-1:0] to_signed(input logic [SMP_W-1:0] s);
    return signed'(s ^ MIDSCALE);
  endfunction
endpackage

// File: rtl/adc_wave_meter_if.sv
// ADC pin side and measurement result bundle of adc_wave_meter.
interface adc_wave_meter_if import wave_pkg::*; #(
  parameter int unsigned FREQ_W = 28
) ();
  logic [SMP_W-1:0]  ad_data;
  logic              ad_clk;
  logic [FREQ_W-1:0] freq_hz;
  logic [SMP_W-1:0]  vpp;
  logic              meas_valid;
  logic              locked;

  modport master (output ad_data, input ad_clk, freq_hz, vpp, meas_valid, locked);
  modport slave  (input ad_data, output ad_clk, freq_hz, vpp, meas_valid, locked);
endinterface

// File: rtl/adc_wave_meter_schmitt_edge_det.sv
// Schmitt trigger on a signed sample; flags each LOW->HIGH transition for one cycle.
module schmitt_edge_det import wave_pkg::*; #(
  parameter int HYST = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [SMP_W-1:0] sgn,
  output logic                    rise_pulse
);
  localparam logic signed [SMP_W-1:0] HYST_S = SMP_W'(HYST);

  logic level;

  always_comb begin
    rise_pulse = !level && (sgn > HYST_S);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
    end else if (!level && (sgn > HYST_S)) begin
      level <= 1'b1;
    end else if (level && (sgn < -HYST_S)) begin
      level <= 1'b0;
    end
  end
endmodule

// File: rtl/adc_wave_meter.sv
// Gated frequency counter and peak-to-peak tracker on the 8-bit offset-binary ADC stream.
module adc_wave_meter import wave_pkg::*; #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int          HYST        = 8,
  parameter int unsigned FREQ_W      = 28
) (
  input logic              clk,
  input logic              rst,
  adc_wave_meter_if.slave  bus
);
  localparam int unsigned CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(GATE_CYCLES - 1);

  logic [SMP_W-1:0]        smp, s2;
  logic signed [SMP_W-1:0] sgn;
  logic                    rise_pulse;
  logic [CNT_W-1:0]        cnt;
  logic                    term;
  logic [FREQ_W-1:0]       edges, edges_tot;
  logic [SMP_W-1:0]        pk_max, pk_min, max_nxt, min_nxt;
  meter_state_t            state;
  logic [FREQ_W-1:0]       freq_q;
  logic [SMP_W-1:0]        vpp_q;
  logic                    valid_q, locked_q;

  assign bus.ad_clk     = clk;
  assign bus.freq_hz    = freq_q;
  assign bus.vpp        = vpp_q;
  assign bus.meas_valid = valid_q;
  assign bus.locked     = locked_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= MIDSCALE;
      s2  <= MIDSCALE;
    end else begin
      smp <= bus.ad_data;
      s2  <= smp;
    end
  end

  assign sgn = to_signed(s2);

  schmitt_edge_det #(.HYST(HYST)) u_schmitt (
    .clk        (clk),
    .rst        (rst),
    .sgn        (sgn),
    .rise_pulse (rise_pulse)
  );

  // Term-cycle edge and sample are folded in before the window closes.
  always_comb begin
    edges_tot = edges;
    if (rise_pulse && (edges != '1)) edges_tot = edges + 1'b1;
  end

  assign max_nxt = (s2 > pk_max) ? s2 : pk_max;
  assign min_nxt = (s2 < pk_min) ? s2 : pk_min;
  assign term    = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      edges    <= '0;
      pk_max   <= '0;
      pk_min   <= '1;
      state    <= WARMUP;
      freq_q   <= '0;
      vpp_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (term) begin
        cnt    <= '0;
        edges  <= '0;
        pk_max <= s2;
        pk_min <= s2;
        case (state)
          WARMUP: state <= RUN;
          RUN: begin
            freq_q   <= edges_tot;
            vpp_q    <= max_nxt - min_nxt;
            valid_q  <= 1'b1;
            locked_q <= 1'b1;
          end
          default: state <= WARMUP;
        endcase
      end else begin
        cnt    <= cnt + 1'b1;
        edges  <= edges_tot;
        pk_max <= max_nxt;
        pk_min <= min_nxt;
      end
    end
  end
endmodule
